// File: rtl/quad_pkg.sv
// Shared types for the quadrature decoder: phase codes, tracker states and defaults.
// Used by quad_filt and quad_dec.
package quad_pkg;

   typedef enum logic [1:0] {
      PH_00 = 2'b00,
      PH_01 = 2'b01,
      PH_11 = 2'b11,
      PH_10 = 2'b10
   } ph_t;

   typedef enum logic {
      INIT  = 1'b0,
      TRACK = 1'b1
   } state_t;

   localparam int unsigned FILT_LEN_DEF = 4;
   localparam int unsigned SYNC_DEPTH   = 2;

   // Forward rotation 00->01->11->10->00
   function automatic ph_t ph_next_up(input ph_t p);
      ph_t r;
      case (p)
         PH_00:   r = PH_01;
         PH_01:   r = PH_11;
         PH_11:   r = PH_10;
         default: r = PH_00;
      endcase
      return r;
   endfunction

   function automatic ph_t ph_next_dn(input ph_t p);
      ph_t r;
      case (p)
         PH_00:   r = PH_10;
         PH_10:   r = PH_11;
         PH_11:   r = PH_01;
         default: r = PH_00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/quad_filt.sv
// One encoder phase bit: two-flop synchronizer, plus a FILT_LEN-sample stability
// filter when QUAD_DEC_FILTER_EN is defined (otherwise the synchronizer drives q).
module quad_filt
`ifdef QUAD_DEC_FILTER_EN
   import quad_pkg::*;
#(
   parameter int unsigned FILT_LEN = FILT_LEN_DEF
)
`endif
(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;

   always_comb begin
      s1_d = d;
      s2_d = s1_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

`ifdef QUAD_DEC_FILTER_EN
   logic [FILT_LEN-1:0] hist_q, hist_d;
   logic                filt_q, filt_d;

   // Level moves only when the last FILT_LEN synchronized samples agree.
   always_comb begin
      hist_d = {hist_q[FILT_LEN-2:0], s2_q};
      filt_d = filt_q;
      if (&hist_d) begin
         filt_d = 1'b1;
      end else if (~|hist_d) begin
         filt_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q <= '0;
         filt_q <= 1'b0;
      end else begin
         hist_q <= hist_d;
         filt_q <= filt_d;
      end
   end

   assign q = filt_q;
`else
   assign q = s2_q;
`endif

endmodule

// File: rtl/quad_dec.sv
// Quadrature decoder: turns encoder phases A/B into count-enable/direction pulses
// and flags illegal two-bit jumps. Optional input filter via QUAD_DEC_FILTER_EN.
module quad_dec
   import quad_pkg::*;
#(
   parameter int unsigned FILT_LEN = FILT_LEN_DEF,
   parameter int unsigned ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a,
   input  logic             b,
   output logic             en,
   output logic             updown,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt
);

`ifdef QUAD_DEC_FILTER_EN
   localparam int unsigned PRIME_N = SYNC_DEPTH + FILT_LEN;
`else
   localparam int unsigned PRIME_N = SYNC_DEPTH;
`endif
   localparam int unsigned PRIME_W = $clog2(SYNC_DEPTH + FILT_LEN + 1);

   logic a_s, b_s;
   ph_t  ph;

`ifdef QUAD_DEC_FILTER_EN
   quad_filt #(.FILT_LEN(FILT_LEN)) u_filt_a (.clk(clk), .rst(rst), .d(a), .q(a_s));
   quad_filt #(.FILT_LEN(FILT_LEN)) u_filt_b (.clk(clk), .rst(rst), .d(b), .q(b_s));
`else
   quad_filt u_filt_a (.clk(clk), .rst(rst), .d(a), .q(a_s));
   quad_filt u_filt_b (.clk(clk), .rst(rst), .d(b), .q(b_s));
`endif

   always_comb ph = ph_t'({a_s, b_s});

   state_t             state_q, state_d;
   ph_t                ph_q, ph_d;
   logic [PRIME_W-1:0] prime_q, prime_d;
   logic               prime_done;
   logic               en_q, en_d;
   logic               err_q, err_d;
   logic               updown_q, updown_d;
   logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

   // INIT waits until the input pipeline holds post-reset samples, so levels
   // present at release load ph_q instead of being decoded as a step.
   always_comb begin
      prime_done = (prime_q == PRIME_W'(PRIME_N));
      prime_d    = prime_done ? prime_q : prime_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= INIT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         INIT:    if (prime_done) state_d = TRACK;
         TRACK:   state_d = TRACK;
         default: state_d = INIT;
      endcase
   end

   always_comb begin
      ph_d      = ph_q;
      en_d      = 1'b0;
      err_d     = 1'b0;
      updown_d  = updown_q;
      err_cnt_d = err_cnt_q;
      case (state_q)
         INIT: begin
            if (prime_done) ph_d = ph;
         end
         TRACK: begin
            ph_d = ph;
            if (ph == ph_next_up(ph_q)) begin
               en_d     = 1'b1;
               updown_d = 1'b0;
            end else if (ph == ph_next_dn(ph_q)) begin
               en_d     = 1'b1;
               updown_d = 1'b1;
            end else if (ph != ph_q) begin
               err_d = 1'b1;
               if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ph_q      <= PH_00;
         prime_q   <= '0;
         en_q      <= 1'b0;
         err_q     <= 1'b0;
         updown_q  <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         ph_q      <= ph_d;
         prime_q   <= prime_d;
         en_q      <= en_d;
         err_q     <= err_d;
         updown_q  <= updown_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign en      = en_q;
   assign err     = err_q;
   assign updown  = updown_q;
   assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_quad_dec.sv
// Self-checking bench for quad_dec: directed scenarios plus random phase walks,
// compared cycle by cycle against a positional (mod-4) reference model.
module tb_quad_dec;

   localparam int unsigned FL   = 4;
   localparam int unsigned EW   = 2;
   localparam int          MAXN = 4096;
   localparam int          H    = 8;
`ifdef QUAD_DEC_FILTER_EN
   localparam int D = 2 + FL;
`else
   localparam int D = 2;
`endif

   logic          clk, rst, a, b;
   logic          en, updown, err;
   logic [EW-1:0] err_cnt;

   quad_dec #(.FILT_LEN(FL), .ERR_W(EW)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b),
      .en(en), .updown(updown), .err(err), .err_cnt(err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [1:0] hist [MAXN];
`ifdef QUAD_DEC_FILTER_EN
   logic [1:0] fm [MAXN];
`endif
   int         n     = 0;
   int         r_cur = 0;
   logic       exp_en, exp_err, exp_ud;
   int         exp_cnt  = 0;
   int         en_seen  = 0;
   int         err_seen = 0;
   logic [1:0] cur = 2'b00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, n, obs, exp);
      end
   endtask

   function automatic int pos(input logic [1:0] c);
      case (c)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] code(input int p);
      case (p % 4)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   // Synchronized sample seen at edge e (cleared until two post-reset captures).
   function automatic logic [1:0] samp(input int e);
      if (e - 2 >= r_cur) return hist[e-2];
      return 2'b00;
   endfunction

   // Phase level presented to the tracker after edge e.
   function automatic logic [1:0] p_at(input int e);
`ifdef QUAD_DEC_FILTER_EN
      return fm[e];
`else
      return samp(e + 1);
`endif
   endfunction

   task automatic tick(input logic r_in, input logic [1:0] ph_in);
      int d;
      if (n >= MAXN) begin
         $display("FAIL cycle_budget: got %0d expected below %0d", n, MAXN);
         $fatal(1, "cycle budget exhausted");
      end
      rst     = r_in;
      a       = ph_in[1];
      b       = ph_in[0];
      hist[n] = ph_in;
      @(posedge clk);
      exp_en  = 1'b0;
      exp_err = 1'b0;
      if (r_in) begin
         r_cur   = n + 1;
         exp_ud  = 1'b0;
         exp_cnt = 0;
`ifdef QUAD_DEC_FILTER_EN
         fm[n] = 2'b00;
`endif
      end else begin
`ifdef QUAD_DEC_FILTER_EN
         for (int k = 0; k < 2; k++) begin
            logic [1:0] s0, si;
            logic       all_eq;
            s0     = samp(n);
            all_eq = 1'b1;
            for (int i = 1; i < int'(FL); i++) begin
               si = samp(n - i);
               if (si[k] != s0[k]) all_eq = 1'b0;
            end
            fm[n][k] = all_eq ? s0[k] : fm[n-1][k];
         end
`endif
         if (n >= r_cur + D + 1) begin
            d = (pos(p_at(n - 1)) - pos(p_at(n - 2)) + 4) % 4;
            case (d)
               1: begin exp_en = 1'b1; exp_ud = 1'b0; end
               3: begin exp_en = 1'b1; exp_ud = 1'b1; end
               2: begin
                  exp_err = 1'b1;
                  if (exp_cnt < (1 << EW) - 1) exp_cnt++;
               end
               default: ;
            endcase
         end
      end
      #1;
      check("en", 32'(en), 32'(exp_en));
      check("err", 32'(err), 32'(exp_err));
      check("updown", 32'(updown), 32'(exp_ud));
      check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
      check("en_err_excl", 32'(en & err), 32'd0);
      if (en === 1'b1) en_seen++;
      if (err === 1'b1) err_seen++;
      n++;
      @(negedge clk);
   endtask

   task automatic hold(input logic [1:0] ph, input int cyc);
      for (int i = 0; i < cyc; i++) tick(1'b0, ph);
      cur = ph;
   endtask

   task automatic do_reset(input logic [1:0] ph, input int cyc);
      for (int i = 0; i < cyc; i++) tick(1'b1, ph);
      cur = ph;
   endtask

   int e0, r0;
   int exp_percycle, exp_glitch;

   initial begin
`ifdef QUAD_DEC_FILTER_EN
      exp_percycle = 0;
      exp_glitch   = 0;
`else
      exp_percycle = 20;
      exp_glitch   = 2;
`endif
      rst = 1'b1;
      a   = 1'b0;
      b   = 1'b0;
      @(negedge clk);

      // Release with both phases high: nothing should be decoded.
      do_reset(2'b11, 3);
      hold(2'b11, 12);
      check("release_quiet_en", 32'(en_seen), 32'd0);
      check("release_quiet_err", 32'(err_seen), 32'd0);

      // Forward rotation
      do_reset(2'b00, 2);
      hold(2'b00, H);
      e0 = en_seen;
      hold(2'b01, H); hold(2'b11, H); hold(2'b10, H); hold(2'b00, H);
      check("up_pulses", 32'(en_seen - e0), 32'd4);

      // Reverse rotation then immediate reversal
      e0 = en_seen;
      hold(2'b10, H); hold(2'b11, H); hold(2'b01, H); hold(2'b00, H);
      check("down_pulses", 32'(en_seen - e0), 32'd4);
      e0 = en_seen;
      hold(2'b01, H);
      check("reversal_pulse", 32'(en_seen - e0), 32'd1);

      // Illegal jumps, counter saturates at 3 with two bits
      do_reset(2'b00, 2);
      hold(2'b00, H);
      r0 = err_seen;
      e0 = en_seen;
      hold(2'b11, H); hold(2'b00, H); hold(2'b11, H); hold(2'b00, H); hold(2'b11, H);
      check("jump_errs", 32'(err_seen - r0), 32'd5);
      check("jump_no_en", 32'(en_seen - e0), 32'd0);
      check("jump_sat", 32'(err_cnt), 32'd3);

      // Back-to-back steps every cycle, both directions
      do_reset(2'b00, 2);
      hold(2'b00, H);
      e0 = en_seen;
      for (int i = 1; i <= 12; i++) tick(1'b0, code(i));
      for (int i = 11; i >= 4; i--) tick(1'b0, code(i));
      hold(2'b00, H + 4);
      check("percycle_pulses", 32'(en_seen - e0), 32'(exp_percycle));

      // Two-cycle glitch on a
      e0 = en_seen;
      tick(1'b0, 2'b10);
      tick(1'b0, 2'b10);
      hold(2'b00, H + 4);
      check("glitch_pulses", 32'(en_seen - e0), 32'(exp_glitch));

      // Reset right after a step is captured
      e0 = en_seen;
      tick(1'b0, 2'b01);
      do_reset(2'b01, 2);
      hold(2'b01, H + 4);
      check("midrst_no_en", 32'(en_seen - e0), 32'd0);
      check("midrst_cnt", 32'(err_cnt), 32'd0);

      // Random walk with occasional resets
      for (int it = 0; it < 80; it++) begin
         int act, len;
         act = int'($urandom_range(0, 11));
         len = int'($urandom_range(1, 9));
         if (act == 0) begin
            do_reset(code(int'($urandom_range(0, 3))), 2);
         end else begin
            if (act <= 4)      cur = code(pos(cur) + 1);
            else if (act <= 8) cur = code(pos(cur) + 3);
            else if (act <= 9) cur = code(pos(cur) + 2);
            hold(cur, len);
         end
      end
      hold(cur, H + 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
